// File: rtl/wallace_vec_scale.sv
// wallace_vec_scale: handshaked vector-by-scalar multiplier. A NUM_CH-element
// unsigned vector and one scalar are accepted together; LANES Wallace-tree
// multipliers are time-shared over BEATS = ceil(NUM_CH/LANES) cycles to form
// every element*scalar product, and the whole product vector is then offered
// on a valid/ready port.
//
// Ports:
//   clk, rst_n          single rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   in_vec, scalar      element i at in_vec[i*DATA_W +: DATA_W]
//   out_valid/out_ready output handshake; result held until accepted
//   out_vec             product i at out_vec[i*2*DATA_W +: 2*DATA_W]
//   busy                high while computing or holding a result
//   out_sum             sum of all products, present only when the
//                       WVS_SUM_EN macro is defined
//
// Latency: accept at edge k gives out_valid after edge k+BEATS; accepts are
// spaced at least BEATS+2 cycles apart.

module wvs_wallace_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  localparam int PW = 2 * W;
  // Keep at least two rows so the final adder always has two operands.
  localparam int RW = (W < 2) ? 2 : W;

  // Row count left after s layers of 3:2 compression.
  function automatic int rows_after(input int s);
    int n;
    n = W;
    for (int i = 0; i < s; i++) begin
      if (n > 2) n = 2 * (n / 3) + n % 3;
    end
    return n;
  endfunction

  function automatic int stage_count();
    int n;
    int k;
    n = W;
    k = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      k++;
    end
    return k;
  endfunction

  localparam int NST = stage_count();

  logic [PW-1:0] rows [NST+1][RW];

  // Partial products, one shifted row per multiplier bit.
  for (genvar i = 0; i < RW; i++) begin : g_pp
    if (i < W) begin : g_row
      assign rows[0][i] = b[i] ? ({{W{1'b0}}, a} << i) : '0;
    end else begin : g_pad
      assign rows[0][i] = '0;
    end
  end

  // Each layer compresses every full group of three rows into a sum row and
  // a carry row; leftover rows pass straight through to the next layer.
  // Carries out of the top bit are dropped: the true product fits in PW bits,
  // so modular accumulation still gives the exact result.
  for (genvar s = 0; s < NST; s++) begin : g_stage
    localparam int N  = rows_after(s);
    localparam int NN = rows_after(s + 1);
    localparam int G  = N / 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      assign rows[s+1][2*g]   = rows[s][3*g] ^ rows[s][3*g+1] ^ rows[s][3*g+2];
      assign rows[s+1][2*g+1] = ((rows[s][3*g]   & rows[s][3*g+1]) |
                                 (rows[s][3*g]   & rows[s][3*g+2]) |
                                 (rows[s][3*g+1] & rows[s][3*g+2])) << 1;
    end
    for (genvar r = 0; r < N - 3 * G; r++) begin : g_pass
      assign rows[s+1][2*G+r] = rows[s][3*G+r];
    end
    for (genvar z = NN; z < RW; z++) begin : g_zero
      assign rows[s+1][z] = '0;
    end
  end

  assign p = rows[NST][0] + rows[NST][1];
endmodule

module wallace_vec_scale #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 9,
  parameter int LANES  = 3,
  localparam int SUM_W = (NUM_CH > 1) ? 2 * DATA_W + $clog2(NUM_CH) : 2 * DATA_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_vec,
  input  logic [DATA_W-1:0]          scalar,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*2*DATA_W-1:0] out_vec,
  output logic                       busy
`ifdef WVS_SUM_EN
  ,
  output logic [SUM_W-1:0]           out_sum
`endif
);
  localparam int PW     = 2 * DATA_W;
  localparam int BEATS  = (NUM_CH + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                     state;
  logic [BEAT_W-1:0]          beat;
  logic [NUM_CH*DATA_W-1:0]   vec_q;
  logic [DATA_W-1:0]          scal_q;
  logic [PW-1:0]              lane_p [LANES];
`ifdef WVS_SUM_EN
  logic [LANES-1:0]           lane_act;
  logic [SUM_W-1:0]           beat_sum;
`endif

  assign in_ready = (state == IDLE);

  // Lane l handles channel beat*LANES+l. The operand is an AND-OR mux over
  // the beats in which that lane has a real channel; lanes past the last
  // channel in the final beat see zero and are marked inactive.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_W-1:0] opnd [BEATS];
    logic [BEATS-1:0]  hit;
    logic [DATA_W-1:0] a_sel;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
      if (b * LANES + l < NUM_CH) begin : g_used
        assign hit[b]  = (beat == BEAT_W'(b));
        assign opnd[b] = hit[b] ? vec_q[(b*LANES+l)*DATA_W +: DATA_W] : '0;
      end else begin : g_idle
        assign hit[b]  = 1'b0;
        assign opnd[b] = '0;
      end
    end

    always_comb begin
      a_sel = '0;
      for (int b = 0; b < BEATS; b++) a_sel = a_sel | opnd[b];
    end

`ifdef WVS_SUM_EN
    assign lane_act[l] = |hit;
`endif

    wvs_wallace_mul #(.W(DATA_W)) u_mul (
      .a (a_sel),
      .b (scal_q),
      .p (lane_p[l])
    );
  end

  // Channel c is written only in beat c/LANES, by lane c%LANES, and is held
  // otherwise, so out_vec stays stable in DONE.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PW-1:0] prod_r;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        prod_r <= '0;
      end else if (state == CALC && beat == BEAT_W'(c / LANES)) begin
        prod_r <= lane_p[c % LANES];
      end
    end
    assign out_vec[c*PW +: PW] = prod_r;
  end

`ifdef WVS_SUM_EN
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_act[l]) beat_sum = beat_sum + SUM_W'(lane_p[l]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      vec_q     <= '0;
      scal_q    <= '0;
`ifdef WVS_SUM_EN
      out_sum   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q   <= in_vec;
            scal_q  <= scalar;
            beat    <= '0;
            busy    <= 1'b1;
            state   <= CALC;
`ifdef WVS_SUM_EN
            out_sum <= '0;
`endif
          end
        end
        CALC: begin
`ifdef WVS_SUM_EN
          out_sum <= out_sum + beat_sum;
`endif
          if (beat == BEAT_W'(BEATS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wallace_vec_scale.sv
module tb_wallace_vec_scale;
  localparam int DW = 8;
  localparam int NC = 9;
  localparam int ND = 3;
  localparam int SW = 2 * DW + $clog2(NC);

  typedef logic [DW-1:0] vec_t [NC];

  logic clk = 1'b0;
  logic rst_n;
  logic [NC*DW-1:0] in_vec;
  logic [DW-1:0] scalar;
  logic in_valid [ND];
  logic out_ready [ND];
  logic in_ready [ND];
  logic out_valid [ND];
  logic busy [ND];
  logic [NC*2*DW-1:0] out_vec [ND];
`ifdef WVS_SUM_EN
  logic [SW-1:0] out_sum [ND];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Three builds of the block: LANES = 3 (default), 9 and 4.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : ((g == 1) ? 9 : 4);
    wallace_vec_scale #(.DATA_W(DW), .NUM_CH(NC), .LANES(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_vec    (in_vec),
      .scalar    (scalar),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_vec   (out_vec[g]),
      .busy      (busy[g])
`ifdef WVS_SUM_EN
      ,
      .out_sum   (out_sum[g])
`endif
    );
  end

  function automatic int lanes_of(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 9 : 4);
  endfunction

  function automatic int beats_of(input int d);
    return (NC + lanes_of(d) - 1) / lanes_of(d);
  endfunction

  function automatic logic [NC*DW-1:0] pack_in(input vec_t v);
    logic [NC*DW-1:0] p;
    p = '0;
    for (int i = 0; i < NC; i++) p = p | ((NC*DW)'(v[i]) << (i * DW));
    return p;
  endfunction

  // Reference: each product is plain integer multiplication.
  function automatic logic [NC*2*DW-1:0] ref_vec(input vec_t v, input logic [DW-1:0] s);
    logic [NC*2*DW-1:0] p;
    longint e;
    p = '0;
    for (int i = 0; i < NC; i++) begin
      e = longint'(v[i]) * longint'(s);
      p = p | ((NC*2*DW)'(e) << (i * 2 * DW));
    end
    return p;
  endfunction

  function automatic longint ref_sum(input vec_t v, input logic [DW-1:0] s);
    longint t;
    t = 0;
    for (int i = 0; i < NC; i++) t = t + longint'(v[i]) * longint'(s);
    return t;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NC; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input int d, input vec_t v, input logic [DW-1:0] s, input string tag);
    logic [NC*2*DW-1:0] t;
    longint e;
    for (int i = 0; i < NC; i++) begin
      t = out_vec[d] >> (i * 2 * DW);
      e = longint'(v[i]) * longint'(s);
      chk($sformatf("%s_p%0d", tag, i), 64'(t[2*DW-1:0]), e);
    end
`ifdef WVS_SUM_EN
    chk({tag, "_sum"}, 64'(out_sum[d]), ref_sum(v, s));
`endif
  endtask

  task automatic wait_ready(input int d, input string tag);
    int n;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 64'(in_ready[d]), 1);
  endtask

  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (out_valid[d] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  // One full transaction with out_ready high; checks latency, products and
  // the single-cycle out_valid pulse.
  task automatic transact(input int d, input vec_t v, input logic [DW-1:0] s, input string tag);
    int n;
    in_vec = pack_in(v);
    scalar = s;
    out_ready[d] = 1'b1;
    in_valid[d] = 1'b1;
    wait_ready(d, tag);
    step();
    in_valid[d] = 1'b0;
    in_vec = pack_in(rand_vec());
    scalar = DW'($urandom);
    chk({tag, "_busy"}, 64'(busy[d]), 1);
    chk({tag, "_nrdy"}, 64'(in_ready[d]), 0);
    wait_valid(d, n);
    chk({tag, "_lat"}, 64'(n), 64'(beats_of(d)));
    check_result(d, v, s, tag);
    step();
    chk({tag, "_vld_drop"}, 64'(out_valid[d]), 0);
    chk({tag, "_idle"}, 64'(in_ready[d]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t va;
    vec_t vb;
    vec_t cv;
    vec_t qv [$];
    logic [DW-1:0] qs [$];
    logic [DW-1:0] sa;
    logic [DW-1:0] sb;
    logic [DW-1:0] cs;
    int n;
    int got;
    int last;
    logic seen;

    rst_n = 1'b0;
    in_vec = '0;
    scalar = '0;
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    step();
    step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_rdy%0d", d), 64'(in_ready[d]), 1);
      chk($sformatf("rst_vld%0d", d), 64'(out_valid[d]), 0);
      chk($sformatf("rst_busy%0d", d), 64'(busy[d]), 0);
      chk($sformatf("rst_vec%0d", d), 64'(|out_vec[d]), 0);
    end
    rst_n = 1'b1;
    step();

    // Elements 1..9 times 3 on every lane configuration.
    for (int i = 0; i < NC; i++) va[i] = DW'(i + 1);
    transact(0, va, 8'd3, "t1");
    transact(1, va, 8'd3, "t5_l9");
    transact(2, va, 8'd3, "t5_l4");

    // Largest operands.
    for (int i = 0; i < NC; i++) va[i] = 8'hFF;
    transact(0, va, 8'hFF, "t2");
    transact(2, va, 8'hFF, "t2_l4");

    // Random vectors on every configuration.
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < ND; d++) begin
        transact(d, rand_vec(), DW'($urandom), $sformatf("rnd%0d_%0d", r, d));
      end
    end

    // Backpressure: result held while out_ready is low and inputs toggle.
    va = rand_vec();
    sa = DW'($urandom);
    vb = rand_vec();
    sb = DW'($urandom);
    in_vec = pack_in(va);
    scalar = sa;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    wait_ready(0, "t3");
    step();
    in_valid[0] = 1'b0;
    wait_valid(0, n);
    chk("t3_lat", 64'(n), 3);
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = 1'($urandom);
      in_vec = pack_in(rand_vec());
      scalar = DW'($urandom);
      step();
      chk("t3_hold_vld", 64'(out_valid[0]), 1);
      chk("t3_hold_nrdy", 64'(in_ready[0]), 0);
      chk("t3_hold_vec", 64'(out_vec[0] === ref_vec(va, sa)), 1);
    end
    check_result(0, va, sa, "t3a");
    in_vec = pack_in(vb);
    scalar = sb;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    step();
    chk("t3_rel_vld", 64'(out_valid[0]), 0);
    chk("t3_rel_rdy", 64'(in_ready[0]), 1);
    step();
    chk("t3_acc_busy", 64'(busy[0]), 1);
    chk("t3_acc_nrdy", 64'(in_ready[0]), 0);
    in_valid[0] = 1'b0;
    wait_valid(0, n);
    chk("t3b_lat", 64'(n), 3);
    check_result(0, vb, sb, "t3b");
    step();

    // Reset during beat 1 of CALC discards the transaction.
    for (int i = 0; i < NC; i++) va[i] = DW'(i + 17);
    in_vec = pack_in(va);
    scalar = 8'd5;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    wait_ready(0, "t4");
    step();
    in_valid[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t4_rdy", 64'(in_ready[0]), 1);
    chk("t4_vld", 64'(out_valid[0]), 0);
    chk("t4_busy", 64'(busy[0]), 0);
    chk("t4_vec", 64'(|out_vec[0]), 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    chk("t4_no_pulse", 64'(seen), 0);

    // Back-to-back accepts with in_valid held high.
    for (int d = 0; d < ND; d++) begin
      qv.delete();
      qs.delete();
      got = 0;
      last = -1;
      out_ready[d] = 1'b1;
      in_valid[d] = 1'b1;
      for (int t = 0; t < 60 && got < 4; t++) begin
        if (out_valid[d] === 1'b1) begin
          if (qv.size() > 0) begin
            chk($sformatf("t6_res%0d_%0d", d, got), 64'(out_vec[d] === ref_vec(qv[0], qs[0])), 1);
            void'(qv.pop_front());
            void'(qs.pop_front());
          end else begin
            chk($sformatf("t6_unexp%0d", d), 64'(qv.size()), 1);
          end
          got++;
        end
        cv = rand_vec();
        cs = DW'($urandom);
        in_vec = pack_in(cv);
        scalar = cs;
        if (in_ready[d] === 1'b1) begin
          qv.push_back(cv);
          qs.push_back(cs);
          if (last >= 0) chk($sformatf("t6_gap%0d", d), 64'(cyc - last), 64'(beats_of(d) + 2));
          last = cyc;
        end
        step();
      end
      chk($sformatf("t6_count%0d", d), 64'(got), 4);
      in_valid[d] = 1'b0;
      wait_ready(d, $sformatf("t6_drain%0d", d));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
